// File: rtl/alu_pkg.sv
// Shared definitions for the registered 8-bit ALU: operand width, opcode map and
// the divide-by-zero result.
package alu_pkg;

  localparam int unsigned Width = 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_SHL  = 4'h4,
    ALU_SHR  = 4'h5,
    ALU_ROL  = 4'h6,
    ALU_ROR  = 4'h7,
    ALU_AND  = 4'h8,
    ALU_OR   = 4'h9,
    ALU_XOR  = 4'hA,
    ALU_NOR  = 4'hB,
    ALU_NAND = 4'hC,
    ALU_XNOR = 4'hD,
    ALU_GT   = 4'hE,
    ALU_EQ   = 4'hF
  } alu_op_e;

  localparam logic [Width-1:0] DivZeroResult = {Width{1'b1}};

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU function plus the carry-out of A+B, which is produced
// for every opcode.
module alu_core
  import alu_pkg::*;
(
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o
);

  logic [Width:0]       sum;
  logic [2*Width-1:0]   prod;
  logic [Width-1:0]     quot;

  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  assign prod    = {{Width{1'b0}}, a_i} * {{Width{1'b0}}, b_i};
  assign quot    = (b_i == '0) ? DivZeroResult : (a_i / b_i);
  assign carry_o = sum[Width];

  always_comb begin
    result_o = '0;
    unique case (alu_op_e'(sel_i))
      ALU_ADD:  result_o = sum[Width-1:0];
      ALU_SUB:  result_o = a_i - b_i;
      ALU_MUL:  result_o = prod[Width-1:0];
      ALU_DIV:  result_o = quot;
      ALU_SHL:  result_o = {a_i[Width-2:0], 1'b0};
      ALU_SHR:  result_o = {1'b0, a_i[Width-1:1]};
      ALU_ROL:  result_o = {a_i[Width-2:0], a_i[Width-1]};
      ALU_ROR:  result_o = {a_i[0], a_i[Width-1:1]};
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_NAND: result_o = ~(a_i & b_i);
      ALU_XNOR: result_o = ~(a_i ^ b_i);
      ALU_GT:   result_o = {{(Width-1){1'b0}}, (a_i > b_i)};
      ALU_EQ:   result_o = {{(Width-1){1'b0}}, (a_i == b_i)};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: captures f(A, B, ALU_Sel) and the add carry every clock, with
// synchronous active-low reset clearing both outputs.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [Width-1:0] ALU_Out,
  output logic             CarryOut
);

  logic [Width-1:0] alu_out_d, alu_out_q;
  logic             carry_d, carry_q;

  alu_core u_core (
    .a_i      (A),
    .b_i      (B),
    .sel_i    (ALU_Sel),
    .result_o (alu_out_d),
    .carry_o  (carry_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
    end
  end

  assign ALU_Out  = alu_out_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations are queued when inputs are driven and
// compared after the capturing edge.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic [3:0] sel;
  logic [7:0] alu_out;
  logic       carry_out;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .ALU_Sel  (sel),
    .ALU_Out  (alu_out),
    .CarryOut (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%02h want=%02h", tag, got, want);
    end
  endtask

  // Independent reference written arithmetically rather than bitwise.
  function automatic exp_t ref_alu(input logic [7:0] x, input logic [7:0] y,
                                   input logic [3:0] s);
    exp_t e;
    int unsigned xi, yi, r;
    xi = x;
    yi = y;
    case (s)
      4'h0: r = xi + yi;
      4'h1: r = xi + 256 - yi;
      4'h2: r = xi * yi;
      4'h3: r = (yi == 0) ? 255 : xi / yi;
      4'h4: r = xi * 2;
      4'h5: r = xi / 2;
      4'h6: r = xi * 2 + xi / 128;
      4'h7: r = xi / 2 + (xi % 2) * 128;
      4'h8: r = xi & yi;
      4'h9: r = xi | yi;
      4'hA: r = xi ^ yi;
      4'hB: r = 255 - (xi | yi);
      4'hC: r = 255 - (xi & yi);
      4'hD: r = 255 - (xi ^ yi);
      4'hE: r = (xi > yi) ? 1 : 0;
      default: r = (xi == yi) ? 1 : 0;
    endcase
    e.res = r[7:0];
    e.c   = ((xi + yi) > 255);
    return e;
  endfunction

  // Drive one vector just after a negedge, check outputs hold, then compare after the edge.
  task automatic step(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic [3:0] s, input logic rst_val, input logic use_model,
                      input logic [7:0] want_res, input logic want_c);
    exp_t e;
    logic [7:0] held_res;
    logic       held_c;
    held_res = alu_out;
    held_c   = carry_out;
    a = x; b = y; sel = s; rst_n = rst_val;
    if (!rst_val) e = '0;
    else if (use_model) e = ref_alu(x, y, s);
    else begin
      e.res = want_res;
      e.c   = want_c;
    end
    exp_q.push_back(e);
    #1;
    check({tag, "_hold"}, {held_c, alu_out[6:0]}, {held_c, held_res[6:0]});
    if (alu_out !== held_res) begin
      check({tag, "_hold_res"}, alu_out, held_res);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_res"}, alu_out, e.res);
    check({tag, "_c"}, {7'b0, carry_out}, {7'b0, e.c});
    @(negedge clk);
  endtask

  logic [7:0] sweep_exp [16];

  initial begin
    sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    rst_n = 1'b0;
    a = '0; b = '0; sel = '0;
    @(negedge clk);

    // Reset with random inputs, then release.
    for (int i = 0; i < 2; i++) begin
      step("reset", 8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
    end
    step("release", 8'hF6, 8'h0A, 4'h1, 1'b1, 1'b0, 8'hEC, 1'b1);

    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep%0h", i), 8'h0A, 8'h02, 4'(i), 1'b1, 1'b0, sweep_exp[i], 1'b0);
    end

    step("f6_add", 8'hF6, 8'h0A, 4'h0, 1'b1, 1'b0, 8'h00, 1'b1);
    step("f6_sub", 8'hF6, 8'h0A, 4'h1, 1'b1, 1'b0, 8'hEC, 1'b1);
    step("f6_mul", 8'hF6, 8'h0A, 4'h2, 1'b1, 1'b0, 8'h9C, 1'b1);
    step("f6_div", 8'hF6, 8'h0A, 4'h3, 1'b1, 1'b0, 8'h18, 1'b1);
    step("f6_rol", 8'hF6, 8'h0A, 4'h6, 1'b1, 1'b0, 8'hED, 1'b1);
    step("f6_ror", 8'hF6, 8'h0A, 4'h7, 1'b1, 1'b0, 8'h7B, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("f6_op%0h", i), 8'hF6, 8'h0A, 4'(i), 1'b1, 1'b1, 8'h00, 1'b0);
    end

    step("div0",  8'h37, 8'h00, 4'h3, 1'b1, 1'b0, 8'hFF, 1'b0);
    step("eq55",  8'h55, 8'h55, 4'hF, 1'b1, 1'b0, 8'h01, 1'b0);
    step("gt55",  8'h55, 8'h55, 4'hE, 1'b1, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 100; i++) begin
      step($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 1'b1,
           8'h00, 1'b0);
    end

    // Sweep with one reset edge in the middle.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("mid%0h", i), 8'hC3, 8'h5A, 4'(i), (i != 7), 1'b1, 8'h00, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
